simon_pipe_arbiter: RTL and testbench

Round-robin front-end that shares one fully pipelined Simon 32/64 core (`simon_pipeline`, one block accepted per cycle, fixed latency) between `N_REQ` independent requesters. Each requester presents a plaintext and its own 64-bit key over a valid/ready handshake. The block issues at most one block per cycle into the core and tracks ownership of every in-flight block with a tag shift register. Each ciphertext is routed back to the requester that issued it.

---
 rtl/simon_pipe_arbiter.sv | 89 ++++++++
 tb/tb_simon_pipe_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/simon_pipe_arbiter.sv
// simon_pipe_arbiter: round-robin front-end sharing one pipelined Simon 32/64 core among N_REQ requesters.
// Each issued block carries a tag through a shift register so its ciphertext returns to the right requester.
module simon_pipe_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           halt,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ*32-1:0]            req_plaintext,
    input  logic [N_REQ*64-1:0]            req_key,
    output logic [N_REQ-1:0]               rsp_valid,
    output logic [31:0]                    rsp_ciphertext,
    output logic                           busy,
    output logic [$clog2(LATENCY+3)-1:0]   inflight,
    output logic                           pipe_start,
    output logic [31:0]                    pipe_plaintext,
    output logic [63:0]                    pipe_keytext,
    input  logic [31:0]                    pipe_ciphertext
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(LATENCY+3);

    logic [IW-1:0]      ptr;
    logic [IW-1:0]      gid;
    logic [IW-1:0]      cand;
    logic [IW-1:0]      pipe_id;
    logic [N_REQ-1:0]   gnt;
    logic               found;
    logic               xfer;
    logic [LATENCY-1:0] tag_v;
    logic [IW-1:0]      tag_id [LATENCY];

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        gnt   = '0;
        gid   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                gnt[cand] = 1'b1;
                gid       = cand;
                found     = 1'b1;
            end
        end
    end

    assign req_ready = (rst || halt) ? '0 : gnt;
    assign xfer      = |req_ready;
    assign busy      = (inflight != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr            <= '0;
            pipe_start     <= 1'b0;
            pipe_plaintext <= '0;
            pipe_keytext   <= '0;
            pipe_id        <= '0;
            tag_v          <= '0;
            rsp_valid      <= '0;
            rsp_ciphertext <= '0;
            inflight       <= '0;
        end else begin
            pipe_start <= xfer;
            if (xfer) begin
                ptr            <= (gid == IW'(N_REQ-1)) ? '0 : gid + IW'(1);
                pipe_plaintext <= req_plaintext[32*gid +: 32];
                pipe_keytext   <= req_key[64*gid +: 64];
                pipe_id        <= gid;
            end
            tag_v     <= {tag_v[LATENCY-2:0], pipe_start};
            rsp_valid <= tag_v[LATENCY-1] ? (N_REQ'(1) << tag_id[LATENCY-1]) : '0;
            if (tag_v[LATENCY-1])
                rsp_ciphertext <= pipe_ciphertext;
            inflight <= inflight + CW'(xfer) - CW'(|rsp_valid);
        end
    end

    // Ids need no reset: they are only consulted when the matching valid bit is set.
    always_ff @(posedge clk) begin
        tag_id[0] <= pipe_id;
        for (int k = 1; k < LATENCY; k++)
            tag_id[k] <= tag_id[k-1];
    end
endmodule

// File: tb/tb_simon_pipe_arbiter.sv
// tb_simon_pipe_arbiter: directed bench for simon_pipe_arbiter with a behavioural Simon 32/64 core model.
module tb_simon_pipe_arbiter;
    localparam int N   = 4;
    localparam int LAT = 32;
    localparam logic [31:0] PT  = 32'h65656877;
    localparam logic [63:0] KEY = 64'h1918111009080100;
    localparam logic [31:0] CT  = 32'hc69be9bb;

    logic            clk = 1'b0;
    logic            rst;
    logic            halt;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_plaintext;
    logic [N*64-1:0] req_key;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_ciphertext;
    logic            busy;
    logic [5:0]      inflight;
    logic            pipe_start;
    logic [31:0]     pipe_plaintext;
    logic [63:0]     pipe_keytext;
    logic [31:0]     pipe_ciphertext;
    logic [31:0]     core_sh [LAT];

    int total = 0;
    int bad   = 0;

    simon_pipe_arbiter #(.N_REQ(N), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_plaintext(req_plaintext), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ciphertext(rsp_ciphertext),
        .busy(busy), .inflight(inflight),
        .pipe_start(pipe_start), .pipe_plaintext(pipe_plaintext),
        .pipe_keytext(pipe_keytext), .pipe_ciphertext(pipe_ciphertext)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] simon_enc(input logic [31:0] pt, input logic [63:0] key);
        logic [15:0] k [32];
        logic [15:0] x, y, t;
        logic [61:0] z;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        k[0] = key[15:0];
        k[1] = key[31:16];
        k[2] = key[47:32];
        k[3] = key[63:48];
        for (int i = 4; i < 32; i++) begin
            t = {k[i-1][2:0], k[i-1][15:3]} ^ k[i-3];
            t = t ^ {t[0], t[15:1]};
            k[i] = ~k[i-4] ^ t ^ {15'd0, z[61-(i-4)]} ^ 16'd3;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]} ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction

    // Core model: fixed LAT-cycle delay of the encryption of whatever is on the issue bus.
    always @(posedge clk) begin
        core_sh[0] <= simon_enc(pipe_plaintext, pipe_keytext);
        for (int i = 1; i < LAT; i++)
            core_sh[i] <= core_sh[i-1];
    end
    assign pipe_ciphertext = core_sh[LAT-1];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [N-1:0] one;
        logic [N-1:0] e;
        int inc, dec;
        one           = 4'b0001;
        rst           = 1'b1;
        halt          = 1'b0;
        req_valid     = 4'hf;
        req_plaintext = {N{PT}};
        req_key       = {N{KEY}};
        #1;
        chk("ready_in_rst", 64'(req_ready), 64'h0);
        tick;
        tick;
        chk("rst_pipe_start", 64'(pipe_start), 64'h0);
        chk("rst_pipe_pt", 64'(pipe_plaintext), 64'h0);
        chk("rst_pipe_key", pipe_keytext, 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_ct", 64'(rsp_ciphertext), 64'h0);
        chk("rst_inflight", 64'(inflight), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);

        // Single request from requester 0
        rst       = 1'b0;
        req_valid = 4'b0001;
        #1;
        chk("single_ready", 64'(req_ready), 64'h1);
        tick;
        req_valid = 4'b0000;
        chk("single_start", 64'(pipe_start), 64'h1);
        chk("single_pt", 64'(pipe_plaintext), 64'(PT));
        chk("single_key", pipe_keytext, KEY);
        chk("single_inflight", 64'(inflight), 64'h1);
        chk("single_busy", 64'(busy), 64'h1);
        for (int i = 0; i < 32; i++) tick;
        chk("single_rsp_early", 64'(rsp_valid), 64'h0);
        tick;
        chk("single_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("single_rsp_ct", 64'(rsp_ciphertext), 64'(CT));
        chk("single_busy_hold", 64'(busy), 64'h1);
        tick;
        chk("single_rsp_off", 64'(rsp_valid), 64'h0);
        chk("single_busy_fall", 64'(busy), 64'h0);
        chk("single_inflight0", 64'(inflight), 64'h0);

        // Full contention: 45 back-to-back grants from ptr=0
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_rsp_ct_clear", 64'(rsp_ciphertext), 64'h0);
        for (int c = 0; c < 80; c++) begin
            req_valid = (c < 45) ? 4'hf : 4'h0;
            #1;
            e = (c < 45) ? (one << (c % 4)) : 4'h0;
            chk($sformatf("full_ready_c%0d", c), 64'(req_ready), 64'(e));
            chk($sformatf("full_start_c%0d", c), 64'(pipe_start), 64'(c >= 1 && c <= 45));
            e = (c >= 34 && c <= 78) ? (one << ((c - 34) % 4)) : 4'h0;
            chk($sformatf("full_rsp_c%0d", c), 64'(rsp_valid), 64'(e));
            if (c >= 34 && c <= 78)
                chk($sformatf("full_ct_c%0d", c), 64'(rsp_ciphertext), 64'(CT));
            inc = (c < 45) ? c : 45;
            dec = ((c < 79) ? c : 79) - 34;
            if (dec < 0) dec = 0;
            chk($sformatf("full_inflight_c%0d", c), 64'(inflight), 64'(inc - dec));
            chk($sformatf("full_busy_c%0d", c), 64'(busy), 64'((inc - dec) != 0));
            tick;
        end

        // Sparse wrap: move ptr to 2, then only req1/req3 valid
        req_valid = 4'b0010;
        #1;
        chk("wrap_set_ptr", 64'(req_ready), 64'h2);
        tick;
        req_valid = 4'b1010;
        #1;
        chk("wrap_first_req3", 64'(req_ready), 64'h8);
        tick;
        req_valid = 4'b0010;
        #1;
        chk("wrap_then_req1", 64'(req_ready), 64'h2);
        tick;
        req_valid = 4'b1111;
        #1;
        chk("wrap_ptr_is_2", 64'(req_ready), 64'h4);
        req_valid = 4'b0000;
        #1;
        tick;
        for (int i = 0; i < 40; i++) tick;
        chk("wrap_drained", 64'(busy), 64'h0);

        // Halt after 5 transfers, drain, then resume from preserved ptr=3
        for (int c = 0; c <= 40; c++) begin
            req_valid = 4'hf;
            halt      = (c >= 5 && c < 40);
            #1;
            e = (c < 5) ? (one << ((2 + c) % 4)) : ((c == 40) ? 4'b1000 : 4'h0);
            chk($sformatf("halt_ready_c%0d", c), 64'(req_ready), 64'(e));
            e = (c >= 34 && c <= 38) ? (one << ((2 + c - 34) % 4)) : 4'h0;
            chk($sformatf("halt_rsp_c%0d", c), 64'(rsp_valid), 64'(e));
            if (c >= 34 && c <= 38)
                chk($sformatf("halt_ct_c%0d", c), 64'(rsp_ciphertext), 64'(CT));
            chk($sformatf("halt_busy_c%0d", c), 64'(busy), 64'(c >= 1 && c <= 38));
            if (c == 40) begin
                req_valid = 4'h0;
                halt      = 1'b0;
                #1;
            end
            tick;
        end

        // Reset with 10 blocks in flight: ptr=3 so grants run 3,0,1,2,...
        for (int c = 0; c < 10; c++) begin
            req_valid = 4'hf;
            #1;
            chk($sformatf("mid_ready_c%0d", c), 64'(req_ready), 64'(one << ((3 + c) % 4)));
            tick;
        end
        chk("mid_inflight10", 64'(inflight), 64'd10);
        rst = 1'b1;
        #1;
        chk("mid_ready_in_rst", 64'(req_ready), 64'h0);
        tick;
        rst       = 1'b0;
        req_valid = 4'h0;
        for (int c = 0; c < 40; c++) begin
            chk($sformatf("mid_norsp_c%0d", c), 64'(rsp_valid), 64'h0);
            chk($sformatf("mid_inflight_c%0d", c), 64'(inflight), 64'h0);
            tick;
        end
        req_valid = 4'b0100;
        #1;
        chk("post_ready_req2", 64'(req_ready), 64'h4);
        tick;
        req_valid = 4'h0;
        for (int i = 0; i < 33; i++) tick;
        chk("post_rsp_valid", 64'(rsp_valid), 64'h4);
        chk("post_rsp_ct", 64'(rsp_ciphertext), 64'(CT));
        tick;
        chk("post_busy_fall", 64'(busy), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
